priority_arbiter: RTL
=====================

# priority_arbiter

Four-requester arbiter that shares one downstream resource (bus slot, datapath port) among requesters `req[3:0]`. Selection uses the team's 4-to-2 priority encoding (index 3 highest) by default, with an optional round-robin mode. The winner is granted, held until it releases or a hold timeout expires, and then the arbiter returns to idle and re-arbitrates.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per owner; 0 disables the timeout.
- `CNT_W`, default 8: hold-counter width; requires `MAX_HOLD < 2**CNT_W`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req`  in  4  request lines; `req[i]` high means requester i wants the resource.
- `done`  in  1  owner release strobe; only meaningful while `busy`.
- `grant`  out  4  one-hot grant, registered; all-zero when nothing is granted.
- `grant_id`  out  2  encoded index of the current owner; 0 when idle.
- `busy`  out  1  high while any grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by `MAX_HOLD`.

## Operation
- State machine: IDLE, GRANT, RELEASE.
- Reset (`rst_n`=0 at an edge): state=IDLE, `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0, hold counter=0, round-robin pointer=3. Reset overrides all other inputs, including an active grant.
- IDLE:
  - If `req`=0, stay in IDLE.
  - Otherwise select a winner, load `grant`/`grant_id`, set `busy`=1 and counter=1, and go to GRANT.
- GRANT: the owner holds `grant` while `req[owner]`=1 and `done`=0. Each held cycle increments the counter, saturating at its maximum. Release conditions are checked in this order:
  - `done`=1: go to RELEASE.
  - `req[owner]`=0: go to RELEASE (implicit release).
  - `MAX_HOLD`≠0 and counter==`MAX_HOLD`: go to RELEASE and pulse `timeout` in the same cycle as the RELEASE state.
  - Requests from other requesters never preempt the owner.
- RELEASE: one dead cycle with `grant`=0, `busy`=0, `grant_id`=0, counter cleared, then IDLE. This guarantees at least one idle cycle between owners.
- Winner selection in fixed mode: highest set index wins (3>2>1>0).
- `done` while idle or in RELEASE is ignored.
- `grant` is always one-hot or zero, and `grant_id` always matches `grant`.

## Timing
- Request-to-grant latency: `req` sampled high at edge N in IDLE gives `grant` high after edge N (visible in cycle N+1).
- Release latency: `done` sampled at edge M gives `grant`=0 after edge M. The earliest next grant is after edge M+2.
- Timeout: with `MAX_HOLD`=K, a continuously requesting owner sees `grant` high for exactly K cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - A 2-bit pointer holds the last winner.
  - The search starts at pointer+1 (mod 4) and wraps upward; the first set request wins.
  - The pointer updates to the winner on each IDLE→GRANT transition.
  - From reset (pointer=3), the search order is 0,1,2,3.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; the pointer logic is absent.
  - A persistent `req[3]` can starve the lower requesters, and this is accepted behaviour.

## Test plan
- Reset mid-grant: `req`=4'b0100, granted; assert `rst_n`=0 for one edge → `grant`=0, `busy`=0, `timeout`=0 on the next cycle. After `rst_n`=1 with `req` still 4'b0100, grant returns 1 cycle later.
- Fixed priority, simultaneous requests: `req`=4'b1011 → `grant`=4'b1000, `grant_id`=3. Then `done`=1 → one cycle of `grant`=0, then `grant`=4'b0010, `grant_id`=1 (requester 3 dropped its request).
- Round-robin rotation (`ARB_ROUND_ROBIN_EN`), `req`=4'b1111 held, `done` pulsed each grant → grant sequence 0,1,2,3,0 with `grant_id` matching. Each grant is separated by exactly one RELEASE cycle.
- Timeout: `MAX_HOLD`=4, `req`=4'b0001 held, `done`=0 → `grant`=4'b0001 for exactly 4 cycles, then `timeout`=1 for one cycle with `grant`=0, then re-grant to requester 0.
- Implicit release and no preemption: owner 1 is granted; raise `req[3]` → `grant` stays 4'b0010. Drop `req[1]` → RELEASE, then `grant`=4'b1000.
- Ignored `done`: pulse `done` while idle with `req`=0 → all outputs stay at their reset values.

Source files
------------

// File: rtl/priority_arbiter.sv
// Four-requester arbiter: fixed priority (3 highest) or, with ARB_ROUND_ROBIN_EN
// defined, round-robin starting after the last winner. Grant is held until release/timeout.
module priority_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t           state, state_nx;
  logic [3:0]       grant_nx;
  logic [1:0]       grant_id_nx;
  logic             busy_nx, timeout_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       win;
  logic             win_vld;
  logic             rel, hold_exp;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr, ptr_nx;
  logic [1:0] idx;

  // Walk the search order backwards so the earliest candidate after ptr wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr <= 2'd3;
    else        ptr <= ptr_nx;
  end

  always_comb begin
    ptr_nx = ptr;
    if (state == IDLE && win_vld) ptr_nx = win;
  end
`else
  always_comb begin
    win_vld = |req;
    if      (req[3]) win = 2'd3;
    else if (req[2]) win = 2'd2;
    else if (req[1]) win = 2'd1;
    else             win = 2'd0;
  end
`endif

  assign rel      = done || !req[grant_id];
  assign hold_exp = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    grant_id_nx = grant_id;
    busy_nx     = busy;
    timeout_nx  = 1'b0;
    cnt_nx      = cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nx    = GRANT;
          grant_nx    = 4'b0001 << win;
          grant_id_nx = win;
          busy_nx     = 1'b1;
          cnt_nx      = CNT_W'(1);
        end
      end
      GRANT: begin
        if (rel || hold_exp) begin
          state_nx    = RELEASE;
          grant_nx    = '0;
          grant_id_nx = '0;
          busy_nx     = 1'b0;
          cnt_nx      = '0;
          timeout_nx  = !rel;
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_nx    = IDLE;
        grant_nx    = '0;
        grant_id_nx = '0;
        busy_nx     = 1'b0;
        cnt_nx      = '0;
      end
      default: begin
        state_nx    = IDLE;
        grant_nx    = '0;
        grant_id_nx = '0;
        busy_nx     = 1'b0;
        cnt_nx      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      grant_id <= grant_id_nx;
      busy     <= busy_nx;
      timeout  <= timeout_nx;
      cnt      <= cnt_nx;
    end
  end

endmodule
